winograd2d_mc: RTL and testbench

Multi-channel Winograd F(2x2,3x3) convolution tile engine. It is the parametrised successor of the single-channel winograd2d. It stores one 3x3 kernel per input channel and streams 4x4 input tiles column by column, one channel after another. It accumulates element-wise products in the Winograd domain and emits one 2x2 output tile per CH channels. It sits between the line-buffer/tile fetcher and the output accumulator, with valid/ready handshakes on all three streams.

---
 rtl/winograd_pkg.sv | 16 +
 rtl/winograd_kernel_xform.sv | 27 ++
 rtl/winograd2d_mc.sv | 149 ++++++++++++++
 tb/tb_winograd2d_mc.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/winograd_pkg.sv
// winograd_pkg: shared states, Winograd F(2x2,3x3) coefficients and width helpers
package winograd_pkg;
    typedef enum logic [2:0] {IDLE, COLLECT, MAC, XFORM, OUT} state_t;
    localparam int BT [4][4] = '{'{1, 0, -1, 0}, '{0, 1, 1, 0}, '{0, -1, 1, 0}, '{0, 1, 0, -1}};
    localparam int G2 [4][3] = '{'{2, 0, 0}, '{1, 1, 1}, '{1, -1, 1}, '{0, 0, 2}};
    localparam int AT [2][4] = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};
    function automatic int accw_min(input int dw, input int ch);
        return 2 * dw + 10 + $clog2(ch);
    endfunction
    function automatic int vw(input int dw);
        return dw + 2;
    endfunction
    function automatic int uw(input int dw);
        return dw + 4;
    endfunction
endpackage

// File: rtl/winograd_kernel_xform.sv
// winograd_kernel_xform: combinational 3x3 kernel to 4x4 U' = (2G) g (2G)^T
module winograd_kernel_xform
    import winograd_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic signed [DW-1:0]     g [3][3],
    output logic signed [uw(DW)-1:0] u [4][4]
);
    localparam int UW = uw(DW);
    logic signed [UW-1:0] t [4][3];
    // row transform then column transform; integer coefficients keep U' exact at 4x scale
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 3; k++) begin
                t[i][k] = '0;
                for (int m = 0; m < 3; m++) t[i][k] = t[i][k] + UW'(G2[i][m]) * UW'(g[m][k]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                u[i][j] = '0;
                for (int k = 0; k < 3; k++) u[i][j] = u[i][j] + t[i][k] * UW'(G2[j][k]);
            end
        end
    end
endmodule

// File: rtl/winograd2d_mc.sv
// winograd2d_mc: multi-channel Winograd F(2x2,3x3) convolution tile engine
module winograd2d_mc
    import winograd_pkg::*;
#(
    parameter int DW   = 16,
    parameter int CH   = 4,
    parameter int ACCW = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic signed [DW-1:0]   w_r1,
    input  logic signed [DW-1:0]   w_r2,
    input  logic signed [DW-1:0]   w_r3,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [DW-1:0]   x_r1,
    input  logic signed [DW-1:0]   x_r2,
    input  logic signed [DW-1:0]   x_r3,
    input  logic signed [DW-1:0]   x_r4,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic signed [ACCW-1:0] res_r1,
    output logic signed [ACCW-1:0] res_r2,
    output logic                   kern_loaded
);
    localparam int UW = uw(DW);
    localparam int CW = CH > 1 ? $clog2(CH) : 1;
    localparam int KN = 1 << CW;
    state_t state, state_n;
    logic [1:0] w_col, col;
    logic [CW-1:0] w_ch, c;
    logic oj, w_acc, in_acc, res_acc;
    logic signed [DW-1:0] wcol [3];
    logic signed [DW-1:0] xcol [4];
    logic signed [DW-1:0] gbuf [3][2];
    logic signed [DW-1:0] gk [3][3];
    logic signed [UW-1:0] un [4][4];
    logic signed [UW-1:0] kstore [KN][4][4];
    logic signed [DW-1:0] d [4][4];
    logic signed [ACCW-1:0] acc [4][4];
    logic signed [ACCW-1:0] acc_n [4][4];
    logic signed [ACCW-1:0] y [2][2];
    logic signed [ACCW-1:0] y_n [2][2];
    logic signed [ACCW-1:0] v, y4;

    assign wcol = '{w_r1, w_r2, w_r3};
    assign xcol = '{x_r1, x_r2, x_r3, x_r4};
    assign w_ready = state == IDLE;
    assign w_acc = w_valid && w_ready;
    assign in_ready = kern_loaded && (state == IDLE || state == COLLECT) && w_col == 2'd0 &&
                      w_ch == '0 && !(state == IDLE && w_valid);
    assign in_acc = in_valid && in_ready;
    assign res_valid = state == OUT;
    assign res_acc = res_valid && res_ready;
    assign res_r1 = oj ? y[0][1] : y[0][0];
    assign res_r2 = oj ? y[1][1] : y[1][0];

    winograd_kernel_xform #(.DW(DW)) u_kx (.g(gk), .u(un));

    // kernel columns 0..1 come from the buffer, column 2 straight from the bus
    always_comb begin
        for (int m = 0; m < 3; m++) begin
            gk[m][0] = gbuf[m][0];
            gk[m][1] = gbuf[m][1];
            gk[m][2] = wcol[m];
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    // next-state: collect 4 columns per channel, MAC each channel, transform, output two beats
    always_comb begin
        state_n = state;
        if ((state == IDLE || state == COLLECT) && in_acc) state_n = col == 2'd3 ? MAC : COLLECT;
        if (state == MAC) state_n = c == CW'(CH - 1) ? XFORM : COLLECT;
        if (state == XFORM) state_n = OUT;
        if (state == OUT && res_acc && oj) state_n = IDLE;
    end

    // Winograd-domain MAC for channel c and the inverse transform of the accumulator
    always_comb begin
        v = '0;
        y4 = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                v = '0;
                for (int k = 0; k < 4; k++)
                    for (int l = 0; l < 4; l++)
                        v = v + ACCW'(BT[i][k]) * ACCW'(BT[j][l]) * ACCW'(d[k][l]);
                acc_n[i][j] = (c == '0 ? '0 : acc[i][j]) + ACCW'(kstore[c][i][j]) * v;
            end
        end
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                y4 = '0;
                for (int k = 0; k < 4; k++)
                    for (int l = 0; l < 4; l++)
                        y4 = y4 + ACCW'(AT[i][k]) * ACCW'(AT[j][l]) * acc[k][l];
                y_n[i][j] = y4 >>> 2;
            end
        end
    end

    // kernel store, input column buffer, accumulator and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            w_col <= '0;
            w_ch <= '0;
            col <= '0;
            c <= '0;
            oj <= 1'b0;
            kern_loaded <= 1'b0;
            for (int m = 0; m < 3; m++) for (int k = 0; k < 2; k++) gbuf[m][k] <= '0;
            for (int n = 0; n < KN; n++) for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) kstore[n][i][j] <= '0;
            for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
                d[i][j] <= '0;
                acc[i][j] <= '0;
            end
            for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) y[i][j] <= '0;
        end else begin
            if (w_acc) begin
                w_col <= w_col == 2'd2 ? 2'd0 : w_col + 2'd1;
                if (w_col != 2'd2) for (int m = 0; m < 3; m++) gbuf[m][w_col[0]] <= wcol[m];
                if (w_col == 2'd2) begin
                    kstore[w_ch] <= un;
                    w_ch <= w_ch == CW'(CH - 1) ? '0 : w_ch + 1'b1;
                end
                if (w_col == 2'd0 && w_ch == '0) kern_loaded <= 1'b0;
                if (w_col == 2'd2 && w_ch == CW'(CH - 1)) kern_loaded <= 1'b1;
            end
            if (in_acc) begin
                for (int i = 0; i < 4; i++) d[i][col] <= xcol[i];
                col <= col + 2'd1;
            end
            if (state == MAC) begin
                acc <= acc_n;
                c <= c == CW'(CH - 1) ? '0 : c + 1'b1;
            end
            if (state == XFORM) y <= y_n;
            if (res_acc) oj <= ~oj;
        end
    end
endmodule

// File: tb/tb_winograd2d_mc.sv
// tb_winograd2d_mc: directed self-checking bench for winograd2d_mc (CH=4)
module tb_winograd2d_mc;
    localparam int DW = 16;
    localparam int CH = 4;
    localparam int ACCW = 48;
    logic clk = 1'b0;
    logic rst, w_valid, w_ready, in_valid, in_ready, res_valid, res_ready, kern_loaded;
    logic signed [DW-1:0] w_r1, w_r2, w_r3, x_r1, x_r2, x_r3, x_r4;
    logic signed [ACCW-1:0] res_r1, res_r2;
    logic signed [DW-1:0] kg [CH][3][3];
    logic signed [DW-1:0] dd [4][4];
    int n_assert = 0;
    int n_fail = 0;

    winograd2d_mc #(.DW(DW), .CH(CH), .ACCW(ACCW)) dut (
        .clk(clk), .rst(rst),
        .w_valid(w_valid), .w_ready(w_ready), .w_r1(w_r1), .w_r2(w_r2), .w_r3(w_r3),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_r1(x_r1), .x_r2(x_r2), .x_r3(x_r3), .x_r4(x_r4),
        .res_valid(res_valid), .res_ready(res_ready), .res_r1(res_r1), .res_r2(res_r2),
        .kern_loaded(kern_loaded)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [ACCW-1:0] obs, input logic signed [ACCW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_kern(input int ch, input logic signed [DW-1:0] val);
        for (int m = 0; m < 3; m++) for (int k = 0; k < 3; k++) kg[ch][m][k] = val;
    endtask

    task automatic clr_kern();
        for (int ch = 0; ch < CH; ch++) set_kern(ch, 16'sd0);
    endtask

    task automatic load_w();
        for (int ch = 0; ch < CH; ch++) begin
            for (int k = 0; k < 3; k++) begin
                w_valid = 1'b1;
                w_r1 = kg[ch][0][k];
                w_r2 = kg[ch][1][k];
                w_r3 = kg[ch][2][k];
                #1 chk("w_ready", w_ready, 1'b1);
                @(posedge clk);
                @(negedge clk);
                chk("kern_loaded", kern_loaded, (ch == CH - 1 && k == 2));
            end
        end
        w_valid = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic send_col(input logic signed [DW-1:0] a, b, e, f);
        int n;
        n = 0;
        in_valid = 1'b1;
        x_r1 = a;
        x_r2 = b;
        x_r3 = e;
        x_r4 = f;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("col_ready", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_tile();
        for (int ch = 0; ch < CH; ch++) begin
            for (int k = 0; k < 4; k++) send_col(dd[0][k], dd[1][k], dd[2][k], dd[3][k]);
            chk("mac_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        chk("lat_mac_valid", res_valid, 1'b0);
        @(negedge clk);
        chk("lat_xform_valid", res_valid, 1'b0);
        @(negedge clk);
        chk("lat_out_valid", res_valid, 1'b1);
    endtask

    task automatic get_res(input logic signed [ACCW-1:0] a0, b0, a1, b1);
        chk("b0_valid", res_valid, 1'b1);
        chk("b0_r1", res_r1, a0);
        chk("b0_r2", res_r2, b0);
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b1_valid", res_valid, 1'b1);
        chk("b1_r1", res_r1, a1);
        chk("b1_r2", res_r2, b1);
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("done_valid", res_valid, 1'b0);
        chk("done_w_ready", w_ready, 1'b1);
    endtask

    task automatic ramp_d();
        for (int i = 0; i < 4; i++) for (int k = 0; k < 4; k++) dd[i][k] = DW'(4 * i + k);
    endtask

    task automatic fill_d(input logic signed [DW-1:0] val);
        for (int i = 0; i < 4; i++) for (int k = 0; k < 4; k++) dd[i][k] = val;
    endtask

    initial begin
        rst = 1'b1;
        w_valid = 1'b0;
        in_valid = 1'b0;
        res_ready = 1'b0;
        {w_r1, w_r2, w_r3} = '0;
        {x_r1, x_r2, x_r3, x_r4} = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_r1", res_r1, 48'sd0);
        chk("rst_res_r2", res_r2, 48'sd0);
        chk("rst_kern_loaded", kern_loaded, 1'b0);
        chk("rst_w_ready", w_ready, 1'b1);
        in_valid = 1'b1;
        #1 chk("rst_in_ready_unloaded", in_ready, 1'b0);
        in_valid = 1'b0;

        // all-ones kernel on channel 0 only, all-ones data
        clr_kern();
        set_kern(0, 16'sd1);
        load_w();
        fill_d(16'sd1);
        send_tile();
        get_res(48'sd9, 48'sd9, 48'sd9, 48'sd9);

        // centre-tap kernel on channel 0, ramp data
        clr_kern();
        kg[0][1][1] = 16'sd1;
        load_w();
        ramp_d();
        send_tile();
        get_res(48'sd5, 48'sd9, 48'sd6, 48'sd10);

        // +1 and -1 kernels on channels 0 and 1 cancel
        clr_kern();
        set_kern(0, 16'sd1);
        set_kern(1, -16'sd1);
        load_w();
        fill_d(16'sd1);
        send_tile();
        get_res(48'sd0, 48'sd0, 48'sd0, 48'sd0);

        // output backpressure with stray w_valid/in_valid while holding
        clr_kern();
        kg[0][1][1] = 16'sd1;
        load_w();
        ramp_d();
        send_tile();
        w_valid = 1'b1;
        in_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            #1;
            chk("bp_valid", res_valid, 1'b1);
            chk("bp_r1", res_r1, 48'sd5);
            chk("bp_r2", res_r2, 48'sd9);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_w_ready", w_ready, 1'b0);
            chk("bp_kern_loaded", kern_loaded, 1'b1);
            @(negedge clk);
        end
        w_valid = 1'b0;
        in_valid = 1'b0;
        get_res(48'sd5, 48'sd9, 48'sd6, 48'sd10);
        repeat (3) begin
            @(negedge clk);
            chk("bp_no_extra_beat", res_valid, 1'b0);
        end

        // extreme negative values on every channel
        for (int ch = 0; ch < CH; ch++) set_kern(ch, -16'sd32768);
        load_w();
        fill_d(-16'sd32768);
        send_tile();
        get_res(48'sd38654705664, 48'sd38654705664, 48'sd38654705664, 48'sd38654705664);

        // reset after the second column of a tile
        clr_kern();
        kg[0][1][1] = 16'sd1;
        load_w();
        fill_d(16'sd7);
        send_col(dd[0][0], dd[1][0], dd[2][0], dd[3][0]);
        send_col(dd[0][1], dd[1][1], dd[2][1], dd[3][1]);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_res_valid", res_valid, 1'b0);
        chk("mid_rst_res_r1", res_r1, 48'sd0);
        chk("mid_rst_res_r2", res_r2, 48'sd0);
        chk("mid_rst_kern_loaded", kern_loaded, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b0);

        // stale kernel first, then weights win over inputs in IDLE
        load_w();
        w_valid = 1'b1;
        in_valid = 1'b1;
        w_r1 = kg[0][0][0];
        w_r2 = kg[0][1][0];
        w_r3 = kg[0][2][0];
        #1;
        chk("prio_in_ready", in_ready, 1'b0);
        chk("prio_w_ready", w_ready, 1'b1);
        load_w();
        chk("prio_idle_after_load", w_ready, 1'b1);
        ramp_d();
        send_tile();
        get_res(48'sd5, 48'sd9, 48'sd6, 48'sd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
